// File: rtl/syncfifo_pkg.sv
// Shared constants and types for the syncfifo read/write-side adapters.
// Holds the FIFO read-latency selectors, the skid buffer occupancy encoding,
// and a helper that computes the next occupancy from push/pop.
package syncfifo_pkg;

  localparam int RD_LAT_FWFT   = 0;
  localparam int RD_LAT_NORMAL = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Occupancy after one cycle of push/pop; push and pop together leave it unchanged.
  function automatic logic [1:0] occ_step(input logic [1:0] occ, input logic push, input logic pop);
    logic [1:0] nxt;
    nxt = occ + {1'b0, push} - {1'b0, pop};
    return nxt;
  endfunction

endpackage

// File: rtl/syncfifo_rd_skid.sv
// Two-entry skid buffer: head register feeds the stream output directly,
// tail register catches the beat that arrives while the head is stalled.
// All state is held in load-enable registers with a synchronous reset.
module syncfifo_rd_skid
  import syncfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  occ_t                  occ_r;
  occ_t                  occ_next_s;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] head_next_s;
  logic [DATA_WIDTH-1:0] tail_next_s;
  logic                  valid_r;
  logic                  ld_en_s;

  assign ld_en_s = push | pop;

  // Next-state of occupancy and data slots; the head always holds the oldest beat.
  always_comb begin
    occ_next_s  = occ_r;
    head_next_s = head_r;
    tail_next_s = tail_r;
    case (occ_r)
      OCC_EMPTY: begin
        if (push) begin
          head_next_s = din;
          occ_next_s  = OCC_ONE;
        end else begin
          occ_next_s  = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_next_s = din;
        end else if (push) begin
          tail_next_s = din;
          occ_next_s  = OCC_TWO;
        end else if (pop) begin
          occ_next_s  = OCC_EMPTY;
        end else begin
          occ_next_s  = OCC_ONE;
        end
      end
      OCC_TWO: begin
        // A same-cycle refill (pop-through) advances the head and refills the tail.
        if (pop && push) begin
          head_next_s = tail_r;
          tail_next_s = din;
        end else if (pop) begin
          head_next_s = tail_r;
          occ_next_s  = OCC_ONE;
        end else begin
          occ_next_s  = OCC_TWO;
        end
      end
      default: begin
        occ_next_s = OCC_EMPTY;
      end
    endcase
  end

  // Load-enable state registers; idle cycles hold everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= OCC_EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
      valid_r <= 1'b0;
    end else if (ld_en_s) begin
      occ_r   <= occ_next_s;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      valid_r <= (occ_next_s != OCC_EMPTY);
    end else begin
      occ_r   <= occ_r;
      head_r  <= head_r;
      tail_r  <= tail_r;
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign head  = head_r;
  assign occ   = occ_r;

endmodule

// File: rtl/syncfifo_rd_stream.sv
// Read-side consumer for the single-clock syncfifo: pops the FIFO and presents
// its words as a valid/ready stream with registered outputs, 1 beat/clk.
// RD_LAT selects FWFT (0) or normal 1-cycle read latency (1) FIFOs.
// Optional feature: define SYNCFIFO_RD_STREAM_CNT_EN to add the beat_cnt port,
// a 32-bit wrapping count of delivered beats.
module syncfifo_rd_stream
  import syncfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = RD_LAT_FWFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef SYNCFIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  logic       pop;
  logic       push;
  logic       inflight;
  logic [1:0] occ;
  logic [2:0] level;

  assign pop = m_valid & m_ready;

  // Beats that will still be held after this edge: buffered plus in flight, minus the one leaving.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // Pop only when a slot is guaranteed; a slot freed this cycle counts as free.
  assign fifo_rd_en = ~rst & ~fifo_empty & (level < 3'd2);

  if (RD_LAT == RD_LAT_NORMAL) begin : g_normal
    logic inflight_r;

    // Remembers that the FIFO was popped last cycle, so its dout is valid now.
    always_ff @(posedge clk) begin
      if (rst) begin
        inflight_r <= 1'b0;
      end else begin
        inflight_r <= fifo_rd_en;
      end
    end

    assign inflight = inflight_r;
    assign push     = inflight_r;
  end else begin : g_fwft
    assign inflight = 1'b0;
    assign push     = fifo_rd_en;
  end

  syncfifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (fifo_dout),
    .valid(m_valid),
    .head (m_data),
    .occ  (occ)
  );

`ifdef SYNCFIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt_r;

  // Counts accepted output beats; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= 32'd0;
    end else if (pop) begin
      beat_cnt_r <= beat_cnt_r + 32'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_syncfifo_rd_stream.sv
// Scoreboard bench: two DUT instances (FWFT and normal-latency) each read
// their own FIFO model fed with identical words. Every written word is queued
// as expected output; a per-lane monitor pops and compares on each handshake.
module tb_syncfifo_rd_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          m_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ln
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic [DW-1:0] mem [16];
    logic [3:0]    rd_ptr;
    logic [3:0]    wr_ptr;
    logic [4:0]    count;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] exp_q [$];
`ifdef SYNCFIFO_RD_STREAM_CNT_EN
    logic [31:0]   beat_cnt;
`endif

    assign fifo_empty = (count == 5'd0);
    assign fifo_dout  = (g == 0) ? mem[rd_ptr] : dout_q;

    // FIFO model: FWFT lane shows the head word, normal lane registers it on rd_en.
    always @(posedge clk) begin
      if (fifo_rst) begin
        rd_ptr <= 4'd0;
        wr_ptr <= 4'd0;
        count  <= 5'd0;
        dout_q <= '0;
      end else begin
        if (wr_en) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + 4'd1;
        end
        if (fifo_rd_en) begin
          dout_q <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 4'd1;
        end
        count <= count + {4'd0, wr_en} - {4'd0, fifo_rd_en};
      end
    end

    syncfifo_rd_stream #(
      .DATA_WIDTH(DW),
      .RD_LAT    (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd_en(fifo_rd_en),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
`ifdef SYNCFIFO_RD_STREAM_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
    );

    // Monitor: compares each accepted beat against the scoreboard and bounds occupancy.
    always @(negedge clk) begin
      checks++;
      if (({1'b0, u_dut.occ} + {2'b00, u_dut.inflight}) > 3'd2) begin
        failures++;
        $display("FAIL lat%0d_occ_bound: occ=%0d inflight=%0d expected occ+inflight<=2",
                 g, u_dut.occ, u_dut.inflight);
      end
      if (m_valid && m_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL lat%0d_extra_beat: got 0x%0h expected no beat", g, m_data);
        end else begin
          chk($sformatf("lat%0d_beat", g), 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    ln[0].exp_q.push_back(d);
    ln[1].exp_q.push_back(d);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    push_word(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n       = 0;
    m_ready = 1'b1;
    while ((ln[0].exp_q.size() != 0 || ln[1].exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_drain_timeout: got %0d/%0d beats left expected 0",
               name, ln[0].exp_q.size(), ln[1].exp_q.size());
    end
    step();
    step();
    chk({name, "_idle_lat0"}, 32'(ln[0].m_valid), 32'd0);
    chk({name, "_idle_lat1"}, 32'(ln[1].m_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    fifo_rst = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    m_ready  = 1'b0;
    step();
    step();
    chk("rst_valid_lat0", 32'(ln[0].m_valid), 32'd0);
    chk("rst_valid_lat1", 32'(ln[1].m_valid), 32'd0);
    chk("rst_data_lat0", 32'(ln[0].m_data), 32'd0);
    fifo_rst = 1'b0;

    // Preload 01..04 while the reader is held in reset, then release with m_ready=1.
    for (int i = 1; i <= 4; i++) write_word(DW'(i));
    chk("rst_rd_en_lat0", 32'(ln[0].fifo_rd_en), 32'd0);
    chk("rst_rd_en_lat1", 32'(ln[1].fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    rst     = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("lat0_valid_c%0d", c), 32'(ln[0].m_valid), (c <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("lat1_valid_c%0d", c), 32'(ln[1].m_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c <= 4) chk($sformatf("lat0_data_c%0d", c), 32'(ln[0].m_data), 32'(c));
      if (c >= 2) chk($sformatf("lat1_data_c%0d", c), 32'(ln[1].m_data), 32'(c - 1));
    end
    drain("t1");

    // Back-pressure: fill with A0..A5, stall, reader must stop after two pops.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'hA0 + DW'(i));
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("stall_valid_lat0_s%0d", s), 32'(ln[0].m_valid), 32'd1);
      chk($sformatf("stall_valid_lat1_s%0d", s), 32'(ln[1].m_valid), 32'd1);
      chk($sformatf("stall_data_lat0_s%0d", s), 32'(ln[0].m_data), 32'hA0);
      chk($sformatf("stall_data_lat1_s%0d", s), 32'(ln[1].m_data), 32'hA0);
    end
    chk("stall_fifo_cnt_lat0", 32'(ln[0].count), 32'd4);
    chk("stall_fifo_cnt_lat1", 32'(ln[1].count), 32'd4);
    chk("stall_occ_lat0", 32'(ln[0].u_dut.occ), 32'd2);
    chk("stall_occ_lat1", 32'(ln[1].u_dut.occ), 32'd2);
    chk("stall_rd_en_lat0", 32'(ln[0].fifo_rd_en), 32'd0);
    chk("stall_rd_en_lat1", 32'(ln[1].fifo_rd_en), 32'd0);
    drain("t3");

    // m_ready toggling 1010 with random writes into the FIFO.
    for (int i = 0; i < 48; i++) begin
      m_ready = (i % 2 == 0);
      if ($urandom_range(0, 1) == 1 && ln[0].count < 5'd12 && ln[1].count < 5'd12) begin
        push_word(DW'($urandom));
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    drain("t4");

    // Reset mid-stream with both buffers full; all held beats are dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'hB0 + DW'(i));
    step();
    step();
    chk("pre_rst_occ_lat0", 32'(ln[0].u_dut.occ), 32'd2);
    chk("pre_rst_occ_lat1", 32'(ln[1].u_dut.occ), 32'd2);
    rst      = 1'b1;
    fifo_rst = 1'b1;
    ln[0].exp_q.delete();
    ln[1].exp_q.delete();
    step();
    chk("mid_rst_valid_lat0", 32'(ln[0].m_valid), 32'd0);
    chk("mid_rst_valid_lat1", 32'(ln[1].m_valid), 32'd0);
    chk("mid_rst_occ_lat0", 32'(ln[0].u_dut.occ), 32'd0);
    chk("mid_rst_occ_lat1", 32'(ln[1].u_dut.occ), 32'd0);
    chk("mid_rst_inflight_lat1", 32'(ln[1].u_dut.inflight), 32'd0);
    chk("mid_rst_rd_en_lat1", 32'(ln[1].fifo_rd_en), 32'd0);
    chk("mid_rst_data_lat0", 32'(ln[0].m_data), 32'd0);
`ifdef SYNCFIFO_RD_STREAM_CNT_EN
    chk("mid_rst_cnt_lat0", ln[0].beat_cnt, 32'd0);
    chk("mid_rst_cnt_lat1", ln[1].beat_cnt, 32'd0);
`endif
    rst      = 1'b0;
    fifo_rst = 1'b0;
    m_ready  = 1'b1;
    step();
    step();
    step();
    chk("post_rst_valid_lat0", 32'(ln[0].m_valid), 32'd0);
    chk("post_rst_valid_lat1", 32'(ln[1].m_valid), 32'd0);

`ifdef SYNCFIFO_RD_STREAM_CNT_EN
    // Beat counter: ten beats, then wrap from all-ones.
    for (int i = 0; i < 10; i++) write_word(8'h10 + DW'(i));
    drain("t6a");
    chk("cnt10_lat0", ln[0].beat_cnt, 32'd10);
    chk("cnt10_lat1", ln[1].beat_cnt, 32'd10);
    m_ready = 1'b0;
    write_word(8'hEE);
    step();
    step();
    force ln[0].u_dut.beat_cnt_r = 32'hFFFF_FFFF;
    force ln[1].u_dut.beat_cnt_r = 32'hFFFF_FFFF;
    step();
    release ln[0].u_dut.beat_cnt_r;
    release ln[1].u_dut.beat_cnt_r;
    drain("t6b");
    chk("cnt_wrap_lat0", ln[0].beat_cnt, 32'd0);
    chk("cnt_wrap_lat1", ln[1].beat_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
